// File: rtl/spi_frame_pkg.sv
// ---------------------------------------------------------------------------
// spi_frame_pkg
// Shared constants and types for the SPI frame controller: command bytes,
// the frame FSM state encoding and the power-on timing configuration.
// ---------------------------------------------------------------------------
package spi_frame_pkg;

    // First byte of a frame selects what the rest of the frame means
    localparam logic [7:0] CMD_CONF_WR = 8'h2A;
    localparam logic [7:0] CMD_DATA_WR = 8'h2B;

    // Timing configuration loaded on reset; byte 0 sits in bits [7:0].
    // Truncated or zero-extended to the configured number of bytes.
    localparam logic [31:0] CFG_DEFAULT = 32'h1008_0402;

    // Frame-level FSM
    //   IDLE : waiting for chip select to go active
    //   CMD  : waiting for the command byte
    //   CONF : collecting timing-config bytes
    //   DATA : streaming payload bytes into the frame RAM
    //   SKIP : frame is of no further interest, wait for its end
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        CONF = 3'd2,
        DATA = 3'd3,
        SKIP = 3'd4
    } frame_state_t;

    // Running frame checksum step
    function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/cs_sync.sv
// ---------------------------------------------------------------------------
// cs_sync
// Brings the raw, asynchronous SPI chip select into the clk_in domain with a
// two-flop synchroniser and flags its rising edge (end of frame).
// All flops reset to 1 so that a reset never manufactures a frame start or a
// frame end by itself.
// ---------------------------------------------------------------------------
module cs_sync (
    input  logic clk_in,
    input  logic rst_in,
    input  logic cs_n_raw,
    output logic cs_n_sync,
    output logic cs_rise
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // Two-flop synchroniser followed by one delay stage for edge detection
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= cs_n_raw;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign cs_n_sync = sync_reg;
    assign cs_rise   = sync_reg & ~prev_reg;

endmodule

// File: rtl/spi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// spi_frame_ctrl
// Interprets byte streams received over SPI as frames delimited by chip
// select. A frame starting with CMD_CONF_WR loads CONF_BYTES timing bytes
// into cfg_data_out; a frame starting with CMD_DATA_WR writes its payload
// into the frame RAM from address 0 and reports the length at frame end.
//
// Optional feature: define SPI_FRAME_CHKSUM_EN to require that the XOR of
// all payload bytes (the last byte being the checksum) is zero. Failing
// frames raise chk_err_out instead of frame_rdy_out.
// ---------------------------------------------------------------------------
module spi_frame_ctrl
    import spi_frame_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int CONF_BYTES = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    spi_cs_n_in,
    input  logic                    byte_rdy_in,
    input  logic [7:0]              byte_data_in,
    output logic                    ram_wr_en_out,
    output logic [ADDR_WIDTH-1:0]   ram_wr_addr_out,
    output logic [7:0]              ram_wr_data_out,
    output logic [8*CONF_BYTES-1:0] cfg_data_out,
    output logic                    cfg_vld_out,
    output logic                    frame_rdy_out,
    output logic [ADDR_WIDTH:0]     frame_len_out,
`ifdef SPI_FRAME_CHKSUM_EN
    output logic                    chk_err_out,
`endif
    output logic                    ovf_err_out
);

    localparam int CFG_W = 8 * CONF_BYTES;
    localparam int CB_W  = $clog2(CONF_BYTES + 1);
    localparam logic [CFG_W-1:0] CFG_INIT  = CFG_W'(CFG_DEFAULT);
    localparam logic [CB_W-1:0]  CONF_LAST = CB_W'(CONF_BYTES - 1);

    // Synchronised chip select
    logic cs_n_sync;
    logic cs_rise;

    cs_sync u_cs_sync (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .cs_n_raw  (spi_cs_n_in),
        .cs_n_sync (cs_n_sync),
        .cs_rise   (cs_rise)
    );

    // FSM and output registers
    frame_state_t            state_reg;
    logic [ADDR_WIDTH:0]     count_reg;
    logic [CB_W-1:0]         conf_cnt_reg;
    logic                    ram_wr_en_reg;
    logic [ADDR_WIDTH-1:0]   ram_wr_addr_reg;
    logic [7:0]              ram_wr_data_reg;
    logic [CFG_W-1:0]        cfg_data_reg;
    logic                    cfg_vld_reg;
    logic                    frame_rdy_reg;
    logic [ADDR_WIDTH:0]     frame_len_reg;
    logic                    ovf_err_reg;
`ifdef SPI_FRAME_CHKSUM_EN
    logic [7:0]              chk_xor_reg;
    logic                    chk_err_reg;
`endif

    // A byte is only accepted when it does not collide with a frame end
    logic byte_take;
    assign byte_take = byte_rdy_in & ~cs_rise;

    // ---------------------------------------------------------------------
    // Config staging: bytes shift in from the top so that after CONF_BYTES
    // bytes the first one received ends up in byte lane 0. commit_byte is
    // the would-be register content including the byte arriving right now,
    // which is also the value copied to cfg_data_out on the final byte.
    // ---------------------------------------------------------------------
    logic [7:0]       staging_reg [CONF_BYTES];
    logic [7:0]       commit_byte [CONF_BYTES];
    logic [CFG_W-1:0] commit_word;
    logic             stage_shift;
    logic             stage_clr;

    assign stage_shift = (state_reg == CONF) && byte_take;
    assign stage_clr   = rst_in || cs_rise ||
                         ((state_reg == CMD) && byte_take && (byte_data_in == CMD_CONF_WR));

    for (genvar gi = 0; gi < CONF_BYTES; gi++) begin : g_stage
        if (gi == CONF_BYTES - 1) begin : g_top
            assign commit_byte[gi] = byte_data_in;
        end else begin : g_mid
            assign commit_byte[gi] = staging_reg[gi+1];
        end
        assign commit_word[8*gi +: 8] = commit_byte[gi];

        // Staging lane: cleared at reset, command and frame end; shifts on each config byte
        always_ff @(posedge clk_in) begin
            if (stage_clr) begin
                staging_reg[gi] <= 8'h00;
            end else if (stage_shift) begin
                staging_reg[gi] <= commit_byte[gi];
            end
        end
    end

    // Frame FSM with registered strobes, RAM write port and status outputs
    always_ff @(posedge clk_in) begin
        ram_wr_en_reg <= 1'b0;
        cfg_vld_reg   <= 1'b0;
        frame_rdy_reg <= 1'b0;
`ifdef SPI_FRAME_CHKSUM_EN
        chk_err_reg   <= 1'b0;
`endif
        if (rst_in) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            conf_cnt_reg    <= '0;
            ram_wr_addr_reg <= '0;
            ram_wr_data_reg <= 8'h00;
            cfg_data_reg    <= CFG_INIT;
            frame_len_reg   <= '0;
            ovf_err_reg     <= 1'b0;
`ifdef SPI_FRAME_CHKSUM_EN
            chk_xor_reg     <= 8'h00;
`endif
        end else if (cs_rise) begin
            // Frame end wins over any byte arriving in the same cycle
            state_reg    <= IDLE;
            conf_cnt_reg <= '0;
            if ((state_reg == DATA) && (count_reg != '0)) begin
`ifdef SPI_FRAME_CHKSUM_EN
                if (chk_xor_reg == 8'h00) begin
                    frame_len_reg <= count_reg;
                    frame_rdy_reg <= 1'b1;
                end else begin
                    chk_err_reg   <= 1'b1;
                end
`else
                frame_len_reg <= count_reg;
                frame_rdy_reg <= 1'b1;
`endif
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!cs_n_sync) begin
                        state_reg <= CMD;
                    end
                end
                CMD: begin
                    if (byte_take) begin
                        if (byte_data_in == CMD_CONF_WR) begin
                            state_reg    <= CONF;
                            conf_cnt_reg <= '0;
                        end else if (byte_data_in == CMD_DATA_WR) begin
                            state_reg   <= DATA;
                            count_reg   <= '0;
                            ovf_err_reg <= 1'b0;
`ifdef SPI_FRAME_CHKSUM_EN
                            chk_xor_reg <= 8'h00;
`endif
                        end else begin
                            state_reg <= SKIP;
                        end
                    end
                end
                CONF: begin
                    if (byte_take) begin
                        if (conf_cnt_reg == CONF_LAST) begin
                            cfg_data_reg <= commit_word;
                            cfg_vld_reg  <= 1'b1;
                            conf_cnt_reg <= '0;
                            state_reg    <= SKIP;
                        end else begin
                            conf_cnt_reg <= conf_cnt_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (byte_take) begin
`ifdef SPI_FRAME_CHKSUM_EN
                        chk_xor_reg <= chk_step(chk_xor_reg, byte_data_in);
`endif
                        // Top count bit set means the RAM is already full
                        if (count_reg[ADDR_WIDTH]) begin
                            ovf_err_reg <= 1'b1;
                        end else begin
                            ram_wr_en_reg   <= 1'b1;
                            ram_wr_addr_reg <= count_reg[ADDR_WIDTH-1:0];
                            ram_wr_data_reg <= byte_data_in;
                            count_reg       <= count_reg + 1'b1;
                        end
                    end
                end
                SKIP: begin
                    state_reg <= SKIP;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ram_wr_en_out   = ram_wr_en_reg;
    assign ram_wr_addr_out = ram_wr_addr_reg;
    assign ram_wr_data_out = ram_wr_data_reg;
    assign cfg_data_out    = cfg_data_reg;
    assign cfg_vld_out     = cfg_vld_reg;
    assign frame_rdy_out   = frame_rdy_reg;
    assign frame_len_out   = frame_len_reg;
    assign ovf_err_out     = ovf_err_reg;
`ifdef SPI_FRAME_CHKSUM_EN
    assign chk_err_out     = chk_err_reg;
`endif

endmodule
